// File: rtl/wpg_pkg.sv
// Shared types and default sizing for the serial waveform pattern generator.
//   wpg_state_t : sequencer state (idle / streaming)
//   WPG_WORD_W  : default bits per pattern word
//   WPG_DEPTH   : default number of pattern words
package wpg_pkg;

   localparam int unsigned WPG_WORD_W = 8;
   localparam int unsigned WPG_DEPTH  = 16;

   typedef enum logic {
      WPG_IDLE = 1'b0,
      WPG_RUN  = 1'b1
   } wpg_state_t;

endpackage : wpg_pkg

// File: rtl/wpg_pattern_mem.sv
// Pattern RAM: DEPTH x WORD_W, synchronous write, asynchronous read, no reset.
// Ports:
//   clk       : write clock
//   wr_en     : write strobe (already qualified by the caller)
//   wr_addr   : write word address
//   wr_data   : write data
//   rd_addr   : read word address
//   rd_data_c : combinational read data
module wpg_pattern_mem
   import wpg_pkg::*;
#(
   parameter int unsigned WORD_W = WPG_WORD_W,
   parameter int unsigned DEPTH  = WPG_DEPTH,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WORD_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WORD_W-1:0] rd_data_c
);

   logic [WORD_W-1:0] mem [DEPTH];

   // Contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data_c = mem[rd_addr];

endmodule : wpg_pattern_mem

// File: rtl/wave_pattern_gen.sv
// Serial waveform generator: streams pattern RAM words out one bit per clock.
// Ports:
//   clk       : rising-edge clock
//   clear     : asynchronous active-high reset (RAM contents are kept)
//   wr_en     : pattern write strobe, honoured only while not busy
//   wr_addr   : pattern write word address
//   wr_data   : pattern write data
//   start     : start request, level sampled each edge while idle
//   stop      : abort request, wins over start and over completion
//   mode_loop : 1 = wrap forever, 0 = one-shot (latched at start)
//   msb_first : emit each word MSB first when 1 (latched at start)
//   last_addr : final word of the pattern (latched at start)
//   wf        : registered waveform bit
//   busy      : high while streaming
//   done      : one-cycle pulse on one-shot completion
//   word_idx  : word of the bit currently on wf
//   bit_idx   : emission position within the word of the bit on wf
module wave_pattern_gen
   import wpg_pkg::*;
#(
   parameter int unsigned WORD_W = WPG_WORD_W,
   parameter int unsigned DEPTH  = WPG_DEPTH,
   parameter int unsigned ADDR_W = $clog2(DEPTH),
   parameter int unsigned BIT_W  = $clog2(WORD_W)
) (
   input  logic              clk,
   input  logic              clear,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WORD_W-1:0] wr_data,
   input  logic              start,
   input  logic              stop,
   input  logic              mode_loop,
   input  logic              msb_first,
   input  logic [ADDR_W-1:0] last_addr,
   output logic              wf,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] word_idx,
   output logic [BIT_W-1:0]  bit_idx
);

   wpg_state_t        state;
   logic              loop_r;
   logic              msb_r;
   logic [ADDR_W-1:0] last_r;

   logic [WORD_W-1:0] rd_data_c;
   logic [ADDR_W-1:0] rd_addr;
   logic [BIT_W-1:0]  rd_pos;
   logic [BIT_W-1:0]  phys;
   logic              msb_sel;
   logic              rd_bit;
   logic              bit_last;
   logic              word_last;
   logic [BIT_W-1:0]  nxt_bit;
   logic [ADDR_W-1:0] nxt_word;

   wpg_pattern_mem #(
      .WORD_W (WORD_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk       (clk),
      .wr_en     (wr_en & ~busy),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_addr   (rd_addr),
      .rd_data_c (rd_data_c)
   );

   // Look-ahead: address and bit position of the bit to show after the next edge.
   // While idle this is (0,0) so an accepted start shows the first bit at once,
   // read before any same-edge write lands.
   always_comb begin
      bit_last  = (bit_idx == BIT_W'(WORD_W - 1));
      word_last = (word_idx == last_r);
      nxt_bit   = bit_idx + BIT_W'(1);
      nxt_word  = word_idx;
      if (bit_last) begin
         nxt_word = word_last ? '0 : word_idx + ADDR_W'(1);
      end
      rd_addr = (state == WPG_RUN) ? nxt_word : '0;
      rd_pos  = (state == WPG_RUN) ? nxt_bit  : '0;
      msb_sel = (state == WPG_RUN) ? msb_r    : msb_first;
      phys    = msb_sel ? (BIT_W'(WORD_W - 1) - rd_pos) : rd_pos;
      rd_bit  = rd_data_c[phys];
   end

   // Sequencer with registered outputs.
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         state    <= WPG_IDLE;
         loop_r   <= 1'b0;
         msb_r    <= 1'b0;
         last_r   <= '0;
         wf       <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         word_idx <= '0;
         bit_idx  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            WPG_IDLE: begin
               if (start && !stop) begin
                  loop_r   <= mode_loop;
                  msb_r    <= msb_first;
                  last_r   <= last_addr;
                  wf       <= rd_bit;
                  word_idx <= '0;
                  bit_idx  <= '0;
                  busy     <= 1'b1;
                  state    <= WPG_RUN;
               end
            end
            WPG_RUN: begin
               if (stop) begin
                  wf       <= 1'b0;
                  busy     <= 1'b0;
                  word_idx <= '0;
                  bit_idx  <= '0;
                  state    <= WPG_IDLE;
               end else if (bit_last && word_last && !loop_r) begin
                  wf       <= 1'b0;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  word_idx <= '0;
                  bit_idx  <= '0;
                  state    <= WPG_IDLE;
               end else begin
                  wf       <= rd_bit;
                  word_idx <= nxt_word;
                  bit_idx  <= nxt_bit;
               end
            end
            default: state <= WPG_IDLE;
         endcase
      end
   end

endmodule : wave_pattern_gen

// File: tb/tb_wave_pattern_gen.sv
// Self-checking bench for wave_pattern_gen with a behavioural pattern model.
module tb_wave_pattern_gen;
   import wpg_pkg::*;

   localparam int unsigned WORD_W = 8;
   localparam int unsigned DEPTH  = 16;
   localparam int unsigned ADDR_W = 4;
   localparam int unsigned BIT_W  = 3;

   logic              clk = 1'b0;
   logic              clear;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [WORD_W-1:0] wr_data;
   logic              start;
   logic              stop;
   logic              mode_loop;
   logic              msb_first;
   logic [ADDR_W-1:0] last_addr;
   logic              wf;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] word_idx;
   logic [BIT_W-1:0]  bit_idx;

   int vectors    = 0;
   int miscompares = 0;

   logic [7:0] model_mem [16];
   int exp_wf[$];
   int exp_word[$];
   int exp_bit[$];

   wave_pattern_gen #(
      .WORD_W (WORD_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clk       (clk),
      .clear     (clear),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .start     (start),
      .stop      (stop),
      .mode_loop (mode_loop),
      .msb_first (msb_first),
      .last_addr (last_addr),
      .wf        (wf),
      .busy      (busy),
      .done      (done),
      .word_idx  (word_idx),
      .bit_idx   (bit_idx)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input int a, input logic [7:0] d);
      wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_data = d;
      step();
      wr_en = 1'b0;
      model_mem[a] = d;
   endtask

   // Expected stream: k-th emitted bit comes from word (k/8) mod (last+1),
   // emission position k mod 8, mapped to a physical bit by the order.
   task automatic build_seq(input int last, input bit msb, input int nbits);
      exp_wf.delete(); exp_word.delete(); exp_bit.delete();
      for (int k = 0; k < nbits; k++) begin
         int w, p;
         w = (k / 8) % (last + 1);
         p = k % 8;
         exp_wf.push_back(int'(model_mem[w][msb ? 7 - p : p]));
         exp_word.push_back(w);
         exp_bit.push_back(p);
      end
   endtask

   // Accept a start, then scramble the config inputs to show they were latched.
   task automatic start_run(input int last, input bit msb, input bit loop);
      mode_loop = loop; msb_first = msb; last_addr = ADDR_W'(last);
      start = 1'b1;
      step();
      start = 1'b0;
      mode_loop = 1'($urandom); msb_first = 1'($urandom); last_addr = ADDR_W'($urandom);
   endtask

   task automatic test_reset();
      clear = 1'b1; wr_en = 0; wr_addr = '0; wr_data = '0; start = 0; stop = 0;
      mode_loop = 0; msb_first = 0; last_addr = '0;
      #12;
      vectors++; if (wf !== 1'b0) begin miscompares++; $display("FAIL reset_wf got %b want 0", wf); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
      vectors++; if (word_idx !== '0 || bit_idx !== '0) begin miscompares++;
         $display("FAIL reset_idx got %0d/%0d want 0/0", word_idx, bit_idx); end
      clear = 1'b0;
      step();
      for (int i = 0; i < 16; i++) write_word(i, 8'($urandom));
   endtask

   task automatic test_basic_pattern();
      int ref_bits[16] = '{1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0};
      write_word(0, 8'hA5);
      write_word(1, 8'h3C);
      start_run(1, 1'b0, 1'b0);
      for (int k = 0; k < 16; k++) begin
         if (k > 0) step();
         vectors++; if (wf !== 1'(ref_bits[k]) || busy !== 1'b1) begin miscompares++;
            $display("FAIL basic_wf[%0d] got wf=%b busy=%b want wf=%0d busy=1", k, wf, busy, ref_bits[k]); end
      end
      step();
      vectors++; if (wf !== 1'b0 || busy !== 1'b0 || done !== 1'b1) begin miscompares++;
         $display("FAIL basic_done got wf=%b busy=%b done=%b want 0/0/1", wf, busy, done); end
      step();
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL basic_done_width got %b want 0", done); end
   endtask

   task automatic test_bit_order();
      write_word(0, 8'h0F);
      for (int pass = 0; pass < 2; pass++) begin
         bit msb;
         logic [7:0] ref_pat;
         msb = (pass == 0);
         ref_pat = msb ? 8'hF0 : 8'h0F;   // bit k = k-th emitted value
         start_run(0, msb, 1'b0);
         for (int k = 0; k < 8; k++) begin
            if (k > 0) step();
            vectors++; if (wf !== ref_pat[k]) begin miscompares++;
               $display("FAIL order_msb%0d[%0d] got %b want %b", msb, k, wf, ref_pat[k]); end
         end
         step();
         vectors++; if (done !== 1'b1 || busy !== 1'b0) begin miscompares++;
            $display("FAIL order_done got done=%b busy=%b want 1/0", done, busy); end
         step();
      end
   endtask

   task automatic test_loop_stop();
      write_word(0, 8'h01);
      start_run(0, 1'b0, 1'b1);
      for (int k = 0; k < 72; k++) begin
         if (k > 0) step();
         vectors++; if (wf !== 1'(k % 8 == 0) || done !== 1'b0 || busy !== 1'b1) begin miscompares++;
            $display("FAIL loop_wf[%0d] got wf=%b done=%b busy=%b want wf=%0d done=0 busy=1",
                     k, wf, done, busy, (k % 8 == 0)); end
      end
      stop = 1'b1;
      step();
      stop = 1'b0;
      vectors++; if (wf !== 0 || busy !== 0 || done !== 0 || word_idx !== '0 || bit_idx !== '0) begin
         miscompares++;
         $display("FAIL loop_stop got wf=%b busy=%b done=%b idx=%0d/%0d want all 0",
                  wf, busy, done, word_idx, bit_idx); end
   endtask

   task automatic test_full_depth();
      bit msb;
      msb = 1'($urandom);
      for (int i = 0; i < 16; i++) write_word(i, 8'(i));
      build_seq(15, msb, 16 * 8 + 16);
      start_run(15, msb, 1'b1);
      for (int k = 0; k < exp_wf.size(); k++) begin
         if (k > 0) step();
         vectors++; if (wf !== 1'(exp_wf[k]) || word_idx !== ADDR_W'(exp_word[k]) ||
                        bit_idx !== BIT_W'(exp_bit[k])) begin miscompares++;
            $display("FAIL full_depth[%0d] got wf=%b idx=%0d/%0d want wf=%0d idx=%0d/%0d",
                     k, wf, word_idx, bit_idx, exp_wf[k], exp_word[k], exp_bit[k]); end
      end
      stop = 1'b1; step(); stop = 1'b0;
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL full_stop got busy=%b want 0", busy); end
   endtask

   task automatic test_clear_mid_run();
      bit msb, loop;
      msb = 1'($urandom); loop = 1'($urandom);
      for (int i = 0; i < 16; i++) write_word(i, 8'($urandom));
      for (int pass = 0; pass < 2; pass++) begin
         int n;
         n = (pass == 0) ? 29 : 128;      // entry 28 is word 3, position 4
         build_seq(15, msb, n);
         start_run(15, msb, loop);
         for (int k = 0; k < n; k++) begin
            if (k > 0) step();
            vectors++; if (wf !== 1'(exp_wf[k]) || word_idx !== ADDR_W'(exp_word[k]) ||
                           bit_idx !== BIT_W'(exp_bit[k])) begin miscompares++;
               $display("FAIL clear_pass%0d[%0d] got wf=%b idx=%0d/%0d want wf=%0d idx=%0d/%0d",
                        pass, k, wf, word_idx, bit_idx, exp_wf[k], exp_word[k], exp_bit[k]); end
         end
         if (pass == 0) begin
            #2 clear = 1'b1;
            #1;
            vectors++; if (wf !== 0 || busy !== 0 || done !== 0 || word_idx !== '0 || bit_idx !== '0) begin
               miscompares++;
               $display("FAIL clear_async got wf=%b busy=%b done=%b idx=%0d/%0d want all 0",
                        wf, busy, done, word_idx, bit_idx); end
            clear = 1'b0;
            step();
         end else begin
            if (!loop) begin
               step();
               vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL clear_restart_done got %b want 1", done); end
            end else begin
               stop = 1'b1; step(); stop = 1'b0;
            end
            step();
         end
      end
   endtask

   task automatic test_ignored_requests();
      write_word(0, 8'h5A);
      build_seq(0, 1'b0, 24);
      start_run(0, 1'b0, 1'b1);
      for (int k = 0; k < 24; k++) begin
         if (k > 0) step();
         vectors++; if (wf !== 1'(exp_wf[k]) || bit_idx !== BIT_W'(exp_bit[k])) begin miscompares++;
            $display("FAIL ignored_run[%0d] got wf=%b bit=%0d want wf=%0d bit=%0d",
                     k, wf, bit_idx, exp_wf[k], exp_bit[k]); end
         wr_en = (k == 3); wr_addr = '0; wr_data = 8'hFF;
         start = (k == 3 || k == 10);
      end
      wr_en = 1'b0; start = 1'b0;
      stop = 1'b1; step(); stop = 1'b0;
      start_run(0, 1'b0, 1'b0);
      for (int k = 0; k < 8; k++) begin
         logic [7:0] ref_pat;
         ref_pat = 8'h5A;
         if (k > 0) step();
         vectors++; if (wf !== ref_pat[k]) begin miscompares++;
            $display("FAIL ignored_ram[%0d] got %b want %b", k, wf, ref_pat[k]); end
      end
      step(); step();
      start = 1'b1; stop = 1'b1;
      step();
      start = 1'b0; stop = 1'b0;
      vectors++; if (busy !== 1'b0 || wf !== 1'b0) begin miscompares++;
         $display("FAIL start_stop_idle got busy=%b wf=%b want 0/0", busy, wf); end
      step();
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL start_stop_after got busy=%b want 0", busy); end
   endtask

   // One-shot runs with a same-edge write at start and noise on wr_en/start while busy.
   task automatic test_random_oneshot();
      for (int it = 0; it < 8; it++) begin
         int last, n, first_bit;
         bit msb;
         logic [7:0] nd;
         last = $urandom_range(0, 15);
         msb  = 1'($urandom);
         nd   = 8'($urandom);
         n    = (last + 1) * 8;
         first_bit = int'(model_mem[0][msb ? 7 : 0]);
         model_mem[0] = nd;
         build_seq(last, msb, n);
         exp_wf[0] = first_bit;
         wr_en = 1'b1; wr_addr = '0; wr_data = nd;
         start_run(last, msb, 1'b0);
         wr_en = 1'b0;
         for (int k = 0; k < n; k++) begin
            if (k > 0) step();
            vectors++; if (wf !== 1'(exp_wf[k]) || word_idx !== ADDR_W'(exp_word[k]) ||
                           bit_idx !== BIT_W'(exp_bit[k]) || busy !== 1'b1 || done !== 1'b0) begin
               miscompares++;
               $display("FAIL rand%0d[%0d] got wf=%b idx=%0d/%0d busy=%b done=%b want wf=%0d idx=%0d/%0d busy=1 done=0",
                        it, k, wf, word_idx, bit_idx, busy, done, exp_wf[k], exp_word[k], exp_bit[k]); end
            if (k < n - 1) begin
               wr_en = ($urandom_range(0, 3) == 0); wr_addr = ADDR_W'($urandom); wr_data = 8'($urandom);
               start = ($urandom_range(0, 3) == 0);
            end else begin
               wr_en = 1'b0; start = 1'b0;
            end
         end
         step();
         vectors++; if (wf !== 0 || busy !== 0 || done !== 1) begin miscompares++;
            $display("FAIL rand%0d_done got wf=%b busy=%b done=%b want 0/0/1", it, wf, busy, done); end
         step();
      end
   endtask

   initial begin
      test_reset();
      test_basic_pattern();
      test_bit_order();
      test_loop_stop();
      test_full_depth();
      test_clear_mid_run();
      test_ignored_requests();
      test_random_oneshot();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_wave_pattern_gen

// File: doc/wave_pattern_gen.md
Name: wave_pattern_gen

Overview:
- Parametrised serial waveform generator: streams a pattern RAM out one bit per clock on `wf`.
- A bit counter selects a bit inside a word; a word counter walks RAM addresses 0..last_addr.
- Adds a runtime-writable pattern RAM, programmable length, loop/one-shot modes, MSB/LSB-first order, start/stop control and status.
- Drives a single waveform pin or test-stimulus line in lab-level systems.

Parameters:
- WORD_W, 8, bits per pattern word (power of 2, >=2)
- DEPTH, 16, number of pattern words (power of 2, >=2)
- ADDR_W, $clog2(DEPTH), word address width (derived)
- BIT_W, $clog2(WORD_W), bit index width (derived)

Ports:
- clk  in  1  clock, rising edge
- clear  in  1  asynchronous active-high reset
- wr_en  in  1  pattern write strobe
- wr_addr  in  ADDR_W  write word address
- wr_data  in  WORD_W  write data
- start  in  1  start request (level, sampled each edge)
- stop  in  1  abort request
- mode_loop  in  1  1 = wrap forever, 0 = one-shot; latched at start
- msb_first  in  1  bit order; latched at start
- last_addr  in  ADDR_W  final word of pattern; latched at start
- wf  out  1  waveform bit, registered
- busy  out  1  high while streaming
- done  out  1  one-cycle pulse on one-shot completion
- word_idx  out  ADDR_W  word of the bit currently on wf
- bit_idx  out  BIT_W  position in word of the bit on wf (0 = first emitted)

Behaviour:
- Reset (clear high, asynchronous): state IDLE; wf=0, busy=0, done=0, word_idx=0, bit_idx=0; internal pointers 0. Pattern RAM contents are not cleared and survive clear. Contents are undefined at power-up.
- States: IDLE, RUN.
- Bit addressing: the physical bit for position p is p when msb_first=0, and WORD_W-1-p when msb_first=1.
- IDLE, start=1 and stop=0 at an edge:
  - Latch mode_loop, msb_first, last_addr.
  - wf <= bit (word 0, position 0); word_idx=0, bit_idx=0; busy<=1; go to RUN.
  - The first bit therefore appears after the accepting edge (latency 1 edge).
- IDLE, start and stop both high: stop wins; remain IDLE.
- RUN, each edge: advance position, then drive wf with that bit. There are no gap cycles between words.
  - Position wraps from WORD_W-1 to 0 and increments the word.
- After the bit (last_addr, WORD_W-1) has been displayed for one cycle:
  - Loop mode: the next bit is (0,0), seamless.
  - One-shot: next edge sets wf<=0, busy<=0, done<=1, state IDLE. done deasserts on the following edge.
- RUN, stop=1: next edge sets wf<=0, busy<=0, word_idx/bit_idx<=0, state IDLE; done stays 0. stop takes priority over completion in the same cycle.
- start while busy is ignored. mode_loop, msb_first and last_addr changes while busy are ignored.
- Writes:
  - Accepted only when busy=0. Synchronous write; the RAM has an asynchronous read port.
  - A write in the same cycle as start is accepted, but the first emitted bit uses the pre-write contents.
  - wr_en while busy=1 is dropped.
- last_addr=0 yields a WORD_W-bit pattern. last_addr=DEPTH-1 uses the full RAM. Word and bit counters wrap naturally at DEPTH and WORD_W.
- clear mid-RUN aborts immediately with no done pulse.

Decomposition:
- Package wpg_pkg: state enum (WPG_IDLE, WPG_RUN) and default WORD_W/DEPTH constants.
- Sub-module wpg_pattern_mem: DEPTH x WORD_W RAM, synchronous write, asynchronous read, no reset.
- FSM, counters and bit select stay in wave_pattern_gen.

Test Plan:
- Defaults. Write mem[0]=8'hA5, mem[1]=8'h3C; last_addr=1, msb_first=0, one-shot; start.
  - wf over 16 cycles = 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0.
  - Then wf=0, busy=0, done=1 for exactly 1 cycle.
- mem[0]=8'h0F; last_addr=0, msb_first=1, one-shot.
  - wf = 0,0,0,0,1,1,1,1, then done pulse.
  - Repeat with msb_first=0: wf = 1,1,1,1,0,0,0,0.
- mem[0]=8'h01; last_addr=0, loop.
  - wf high on every 8th cycle (bit_idx=0) for 64+ cycles; done never asserts.
  - Assert stop: next edge wf=0, busy=0, done=0.
- Full depth: mem[i]=i; last_addr=15, loop.
  - word_idx runs 0..15 then 0 with no gap.
  - The bit after (15,7) is (0,0).
- Mid-run clear: clear at word 3, bit 4 gives an immediate asynchronous wf=0, busy=0, idx=0.
  - Restart reproduces the identical sequence, proving RAM retention.
- Ignored requests:
  - wr_en during RUN leaves RAM unchanged.
  - start during RUN does not restart.
  - start+stop together in IDLE leaves busy=0.
